// File: rtl/mul_modp_serial.sv
// Bit-serial modular multiplier over GF(2^255-19): MSB-first double-and-add,
// one modular doubling and one modular add per cycle, valid/ready on both sides.
module mul_modp_serial #(
  parameter int          N = 255,
  parameter logic [N-1:0] P = 255'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] prod,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [N:0] P1 = {1'b0, P};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next_state;
  logic [N-1:0]  acc, xr, yr;
  logic [CW-1:0] cnt;

  logic [N-1:0]  xred;
  logic [N:0]    dbl;
  logic [N-1:0]  dred;
  logic [N:0]    sum;
  logic [N-1:0]  sred;
  logic          accept;

  // 2^N-1 < 2P, so a single conditional subtract fully reduces any input,
  // and likewise for 2*acc and acc+xr since both terms are already < P.
  always_comb begin
    xred = (x >= P) ? N'(x - P) : x;
    dbl  = {acc, 1'b0};
    dred = (dbl >= P1) ? N'(dbl - P1) : dbl[N-1:0];
    sum  = {1'b0, dred} + {1'b0, (yr[cnt] ? xr : {N{1'b0}})};
    sred = (sum >= P1) ? N'(sum - P1) : sum[N-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      xr   <= '0;
      yr   <= '0;
      cnt  <= '0;
      prod <= '0;
    end else if (accept) begin
      xr  <= xred;
      yr  <= y;
      acc <= '0;
      cnt <= CW'(N - 1);
    end else if (state == RUN) begin
      acc <= sred;
      if (cnt == '0) prod <= sred;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule
